// File: rtl/call_stack.sv
// call_stack: return-address LIFO for CALL/RET. It registers next_pc and redirect for the fetch-path PC mux.
module call_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_call,
    input  logic          i_ret,
    input  logic [AW-1:0] i_pc,
    input  logic [AW-1:0] i_addr,
    input  logic          i_clr_err,
    output logic [AW-1:0] o_next_pc,
    output logic          o_redirect,
    output logic [AW-1:0] o_top,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_ovf,
    output logic          o_udf,
    output logic          o_conflict
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_sp;
    logic [AW-1:0] r_next_pc;
    logic          r_redirect, r_ovf, r_udf, r_conflict;

    logic [AW-1:0] w_ret_addr;
    logic [PW-1:0] w_top_idx;
    logic          w_full, w_empty, w_push, w_pop;

    assign w_ret_addr = i_pc + AW'(1);
    assign w_top_idx  = PW'(r_sp - CW'(1));
    assign w_full     = r_sp == CW'(DEPTH);
    assign w_empty    = r_sp == '0;
    assign w_push     = i_en & i_call & ~i_ret & ~w_full;
    assign w_pop      = i_en & i_ret & ~i_call & ~w_empty;

    // Storage is deliberately not reset; top masks stale entries when empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[PW'(r_sp)] <= w_ret_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp       <= '0;
            r_next_pc  <= '0;
            r_redirect <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_conflict <= 1'b0;
        end else if (i_en) begin
            r_next_pc  <= w_push ? i_addr : w_pop ? r_mem[w_top_idx] : w_ret_addr;
            r_redirect <= w_push | w_pop;
            r_sp       <= w_push ? r_sp + CW'(1) : w_pop ? r_sp - CW'(1) : r_sp;
            // A new error in the same cycle as clr_err keeps the flag set.
            r_ovf      <= (i_call & ~i_ret & w_full) | (r_ovf & ~i_clr_err);
            r_udf      <= (i_ret & ~i_call & w_empty) | (r_udf & ~i_clr_err);
            r_conflict <= (i_call & i_ret) | (r_conflict & ~i_clr_err);
        end else begin
            r_redirect <= 1'b0;
        end
    end

    assign o_next_pc  = r_next_pc;
    assign o_redirect = r_redirect;
    assign o_top      = w_empty ? '0 : r_mem[w_top_idx];
    assign o_count    = r_sp;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_ovf      = r_ovf;
    assign o_udf      = r_udf;
    assign o_conflict = r_conflict;
endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Subroutine call/return unit for the 8-bit CPU. It is the return-side counterpart of the jump unit.
- On CALL it pushes the return address (pc+1) onto a hardware LIFO and redirects to the target. On RET it pops that address back as the next PC.
- Sits beside the jump unit in the fetch path. The decoder drives call/ret; the PC mux selects next_pc when redirect is high.

Parameters:
- DEPTH, 8, number of return-address entries (power of two, >=2)
- AW, 8, address width in bits
- CW, 4, count width; must satisfy 2^CW > DEPTH

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  instruction-valid qualifier; when low, no state changes
- call  input  1  CALL instruction this cycle
- ret  input  1  RET instruction this cycle
- pc  input  AW  address of the current instruction
- addr  input  AW  CALL target address
- clr_err  input  1  clears sticky error flags
- next_pc  output  AW  registered next program counter
- redirect  output  1  registered; 1 = next_pc is a CALL target or return address
- top  output  AW  combinational peek of top entry; 0 when empty
- count  output  CW  current number of valid entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- ovf  output  1  sticky: CALL attempted while full
- udf  output  1  sticky: RET attempted while empty
- conflict  output  1  sticky: call and ret both high with en

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: next_pc=0, redirect=0, count=0, ovf=udf=conflict=0. Stack pointer is 0.
  - Storage entries are not reset; top is forced to 0 when empty.
  - Reset mid-operation discards all entries immediately.
- Arithmetic: return address = pc+1 modulo 2^AW, so pc=8'hFF pushes 8'h00. The stack pointer never wraps; it saturates via the full/empty guards.
- Every action below takes effect at the rising edge, one-cycle latency. next_pc and redirect are valid the cycle after the instruction.
- en=0: all state holds, including next_pc. redirect<=0.
- en=1, call=0, ret=0: next_pc<=pc+1, redirect<=0.
- en=1, call=1, ret=0, not full: mem[sp]<=pc+1, sp<=sp+1, next_pc<=addr, redirect<=1.
- en=1, call=1, ret=0, full: no push; ovf<=1; next_pc<=pc+1; redirect<=0.
- en=1, ret=1, call=0, not empty: next_pc<=mem[sp-1], sp<=sp-1, redirect<=1.
- en=1, ret=1, call=0, empty: no pop; udf<=1; next_pc<=pc+1; redirect<=0.
- en=1, call=1, ret=1: illegal encoding. Stack unchanged, conflict<=1, next_pc<=pc+1, redirect<=0.
- clr_err=1 clears ovf/udf/conflict. If a new error occurs in the same cycle, the set wins.
- Derived outputs:
  - count equals sp.
  - full/empty are combinational from sp.
  - top = mem[sp-1] when not empty, else 0.
- Push-then-pop on consecutive cycles returns the just-pushed value; no bypass is needed because of registered storage.

Test Plan:
- Reset: assert rst_n=0 mid-stream after 3 pushes -> count=0, empty=1, next_pc=0, redirect=0, top=0 immediately, without waiting for a clock edge.
- Nested calls: CALL pc=10 addr=40, then CALL pc=40 addr=80, then RET, RET -> next_pc sequence 40, 80, 41, 11; redirect=1 on each; count 1, 2, 1, 0.
- Wrap: CALL pc=8'hFF addr=8'h20, then RET -> pushed/returned 8'h00.
- Overflow: DEPTH+1 CALLs -> full=1 after DEPTH calls. Extra CALL sets ovf=1, next_pc=pc+1, redirect=0, count stays DEPTH. clr_err -> ovf=0.
- Underflow and conflict: RET on empty -> udf=1, next_pc=pc+1. Then call=ret=1 with count=2 -> conflict=1, count stays 2, top unchanged.
- en gating: call=1 with en=0 -> count, next_pc and top unchanged; redirect=0.
